// File: rtl/branch_compare_pipe.sv
// branch_compare_pipe: two-stage branch-resolution pipeline.
// Stage 1 captures the raw comparison facts of each accepted operation.
// Stage 2 decodes the selected branch condition and the zero flags.
// Valid/ready back-pressure, a synchronous flush and a saturating
// taken-branch counter sit around the datapath.
module branch_compare_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             greater,
  output logic             equal,
  output logic             lesser,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LEZ = 3'b010,
    OP_GTZ = 3'b011,
    OP_LTZ = 3'b100,
    OP_GEZ = 3'b101,
    OP_LT  = 3'b110,
    OP_LTU = 3'b111
  } opE;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic             r_s1Valid;
  logic             r_s1Eq;
  logic             r_s1LtSigned;
  logic             r_s1LtUnsigned;
  logic             r_s1Zero;
  logic             r_s1Sign;
  opE               r_s1Op;
  logic [TAG_W-1:0] r_s1Tag;

  // Stage 2 (output) state
  logic             r_outValid;
  logic             r_taken;
  logic             r_greater;
  logic             r_equal;
  logic             r_lesser;
  logic [TAG_W-1:0] r_outTag;
  logic [CNT_W-1:0] r_takenCount;

  // Handshake wires
  logic w_outFire;
  logic w_s2Load;
  logic w_s1Load;
  logic w_inFire;
  logic w_taken;

  // The output register frees up when empty or being consumed; stage 1 can
  // refill whenever its content is moving forward in the same cycle.
  assign w_outFire = r_outValid & out_ready;
  assign w_s2Load  = ~r_outValid | w_outFire;
  assign w_s1Load  = ~r_s1Valid | w_s2Load;
  assign in_ready  = rst_n & ~flush & w_s1Load;
  assign w_inFire  = in_valid & in_ready;

  // Stage 1 occupancy: filled by an input transfer, emptied when drained or flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
    end else if (w_inFire) begin
      r_s1Valid <= 1'b1;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Stage 1 data: precompute every comparison so stage 2 only has to select.
  always_ff @(posedge clk) begin
    if (w_inFire) begin
      r_s1Eq         <= (a == b);
      r_s1LtSigned   <= ($signed(a) < $signed(b));
      r_s1LtUnsigned <= (a < b);
      r_s1Zero       <= (a == '0);
      r_s1Sign       <= a[WIDTH-1];
      r_s1Op         <= opE'(op);
      r_s1Tag        <= in_tag;
    end
  end

  // Branch condition select from the stage 1 facts.
  always_comb begin
    w_taken = 1'b0;
    case (r_s1Op)
      OP_EQ:   w_taken = r_s1Eq;
      OP_NE:   w_taken = ~r_s1Eq;
      OP_LEZ:  w_taken = r_s1Sign | r_s1Zero;
      OP_GTZ:  w_taken = ~r_s1Sign & ~r_s1Zero;
      OP_LTZ:  w_taken = r_s1Sign;
      OP_GEZ:  w_taken = ~r_s1Sign;
      OP_LT:   w_taken = r_s1LtSigned;
      OP_LTU:  w_taken = r_s1LtUnsigned;
      default: w_taken = 1'b0;
    endcase
  end

  // Output valid: follows stage 1 when the output register loads, killed by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_s2Load) begin
      r_outValid <= r_s1Valid;
    end
  end

  // Output data: only overwritten by a real operation so stalled results hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_taken   <= 1'b0;
      r_greater <= 1'b0;
      r_equal   <= 1'b0;
      r_lesser  <= 1'b0;
      r_outTag  <= '0;
    end else if (w_s2Load && r_s1Valid) begin
      r_taken   <= w_taken;
      r_greater <= ~r_s1Sign & ~r_s1Zero;
      r_equal   <= r_s1Zero;
      r_lesser  <= r_s1Sign;
      r_outTag  <= r_s1Tag;
    end
  end

  // Taken counter: counts consumed taken results, including one consumed during a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_takenCount <= '0;
    end else if (w_outFire && r_taken && (r_takenCount != '1)) begin
      r_takenCount <= r_takenCount + CNT_ONE;
    end
  end

  assign out_valid   = r_outValid;
  assign taken       = r_taken;
  assign greater     = r_greater;
  assign equal       = r_equal;
  assign lesser      = r_lesser;
  assign out_tag     = r_outTag;
  assign taken_count = r_takenCount;

endmodule

// File: tb/tb_branch_compare_pipe.sv
// tb_branch_compare_pipe: directed, table-driven bench for branch_compare_pipe.
// A negedge monitor keeps a queue of expected results and a taken-count model.
module tb_branch_compare_pipe;

  localparam int WIDTH   = 32;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             greater;
  logic             equal;
  logic             lesser;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] taken_count;

  branch_compare_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .greater(greater), .equal(equal), .lesser(lesser),
    .out_tag(out_tag), .taken_count(taken_count)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             t;
    logic             g;
    logic             e;
    logic             l;
    int               cyc;
  } expT;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             t;
    logic             g;
    logic             e;
    logic             l;
  } vecT;

  int  errors = 0;
  int  checks = 0;
  int  cycle = 0;
  int  modelCount = 0;
  bit  latencyCheck = 0;
  expT q[$];
  expT cur;
  expT monE;
  vecT vecs[16];
  logic [9:0] snapshot;

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement
  always @(posedge clk) cycle++;

  // Hard stop in case something never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Drive one operation and hold it until the DUT accepts it (bounded wait)
  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic [2:0] vop, input logic [TAG_W-1:0] vtag,
                               input logic et, input logic eg, input logic ee, input logic el);
    bit accepted = 0;
    a = va; b = vb; op = vop; in_tag = vtag; in_valid = 1'b1;
    cur.tag = vtag; cur.t = et; cur.g = eg; cur.e = ee; cur.l = el; cur.cyc = 0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk); #1;
    end
    checkOutput("accept timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  // Wait until every expected result has been consumed (bounded)
  task automatic waitDrain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain pending results", q.size(), 0);
  endtask

  // Monitor: compare consumed results in order, model the counter, track accepts
  always @(negedge clk) begin
    checkOutput("taken_count", taken_count, modelCount);
    if (!rst_n) begin
      q.delete();
      modelCount = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected out_valid", out_valid, 0);
        end else begin
          monE = q.pop_front();
          checkOutput("result {taken,g,e,l,tag}", {taken, greater, equal, lesser, out_tag},
                      {monE.t, monE.g, monE.e, monE.l, monE.tag});
          if (latencyCheck) checkOutput("latency", cycle - monE.cyc, 2);
          if (monE.t && modelCount < CNT_MAX) modelCount++;
        end
      end
      if (in_valid && in_ready) begin
        cur.cyc = cycle;
        q.push_back(cur);
      end
      if (flush) q.delete();
    end
  end

  initial begin
    // Vectors: zero flags with LEZ, all eight ops on a=-1,b=1, signed/unsigned edges
    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 3'b010, 5'd20, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0000, 3'b010, 5'd21, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0000, 3'b010, 5'd22, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_0007, 32'h0000_0007, 3'b000, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{32'h0000_0000, 32'h0000_0001, 3'b101, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{32'h0000_0000, 32'h0000_0001, 3'b011, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; in_tag = '0;
    cur = '{default: '0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", {out_valid, taken, greater, equal, lesser, out_tag, taken_count},
                '0);
    checkOutput("reset in_ready", in_ready, 0);
    rst_n = 1'b1;

    // Table stream, back-to-back with out_ready high: one result per cycle, latency 2
    latencyCheck = 1;
    for (int i = 0; i < 16; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag,
                    vecs[i].t, vecs[i].g, vecs[i].e, vecs[i].l);
    waitDrain(20);
    checkOutput("idle after stream", out_valid, 0);

    // Back-pressure: two accepts fill the pipe, then in_ready drops and outputs hold
    latencyCheck = 0;
    out_ready = 1'b0;
    applyStimulus(32'h0000_0003, 32'h0000_0003, 3'b000, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFE, 32'h0000_0000, 3'b101, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    a = 32'h0000_0000; b = 32'h0000_0005; op = 3'b001; in_tag = 5'd3; in_valid = 1'b1;
    cur.tag = 5'd3; cur.t = 1'b1; cur.g = 1'b0; cur.e = 1'b1; cur.l = 1'b0;
    snapshot = {out_valid, taken, greater, equal, lesser, out_tag};
    checkOutput("stalled head", snapshot, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1});
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("in_ready under stall", in_ready, 0);
      checkOutput("stall hold", {out_valid, taken, greater, equal, lesser, out_tag}, snapshot);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(32'h0000_0000, 32'h0000_0005, 3'b001, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    waitDrain(20);
    checkOutput("idle after back-pressure", out_valid, 0);

    // Flush with two in flight; the input offered during flush is refused
    latencyCheck = 1;
    applyStimulus(32'h0000_0005, 32'h0000_0000, 3'b011, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 3'b000, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    a = 32'h1; b = 32'h1; op = 3'b000; in_tag = 5'd7;
    @(negedge clk);
    checkOutput("in_ready during flush", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("out_valid after flush", out_valid, 0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    waitDrain(20);
    checkOutput("idle after flush", out_valid, 0);

    // Counter saturation: clear by reset, then ten taken results, then a not-taken one
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("count cleared", taken_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(32'h7, 32'h7, 3'b000, TAG_W'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    waitDrain(20);
    checkOutput("count saturated", taken_count, CNT_MAX);
    applyStimulus(32'h7, 32'h7, 3'b001, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    waitDrain(20);
    checkOutput("count after not-taken", taken_count, CNT_MAX);

    // Reset with two operations in flight and a result presented
    latencyCheck = 0;
    out_ready = 1'b0;
    applyStimulus(32'h1, 32'h1, 3'b000, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h2, 32'h2, 3'b000, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("presented before reset", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("out_valid after reset", out_valid, 0);
    checkOutput("count after reset", taken_count, 0);
    checkOutput("in_ready in reset", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      checkOutput("no result after reset", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
